// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - operand, control and HI/LO result bundle for the multiply/divide unit
interface mdu_iterative_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cancel;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a_in, b_in, cancel, wr_hi, wr_lo, wdata,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a_in, b_in, cancel, wr_hi, wr_lo, wdata,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Works on operand magnitudes, retiring BPC bits per cycle; signs are fixed up in FIX.
module mdu_iterative #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input logic           clk,
    input logic           rst,
    mdu_iterative_if.slave bus
);
    localparam int N  = WIDTH / BPC;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic               dz_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               div_zero_q;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH+BPC-1:0] mul_sum;
    logic [WIDTH:0]     rem_t;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign a_neg = ~bus.op[0] & bus.a_in[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b_in[WIDTH-1];
    assign a_mag = a_neg ? -bus.a_in : bus.a_in;
    assign b_mag = b_neg ? -bus.b_in : bus.b_in;

    // Divide: BPC restoring steps on {remainder, dividend/quotient}.
    // Multiply: add multiplicand * low digit into the top half, then shift right by BPC.
    always_comb begin
        acc_d   = acc_q;
        mul_sum = '0;
        rem_t   = '0;
        if (is_div_q) begin
            for (int i = 0; i < BPC; i++) begin
                rem_t = {acc_d[2*WIDTH-1:WIDTH], acc_d[WIDTH-1]};
                if (rem_t >= {1'b0, opnd_q}) begin
                    rem_t = rem_t - {1'b0, opnd_q};
                    acc_d = {rem_t[WIDTH-1:0], acc_d[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_t[WIDTH-1:0], acc_d[WIDTH-2:0], 1'b0};
                end
            end
        end else begin
            mul_sum = {{BPC{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}
                    + ({{BPC{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[BPC-1:0]});
            acc_d   = {mul_sum, acc_q[WIDTH-1:BPC]};
        end
    end

    always_comb begin
        prod_fix = neg_lo_q ? -acc_q : acc_q;
        if (!is_div_q) begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            fix_hi = a_q;
            fix_lo = '1;
        end else begin
            fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fix_lo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.wr_hi) hi_q <= bus.wdata;
                    if (bus.wr_lo) lo_q <= bus.wdata;
                    if (bus.start && !bus.cancel) begin
                        state_q    <= S_CALC;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        is_div_q   <= bus.op[1];
                        neg_lo_q   <= a_neg ^ b_neg;
                        neg_hi_q   <= bus.op[1] ? a_neg : (a_neg ^ b_neg);
                        dz_q       <= bus.op[1] && (bus.b_in == '0);
                        acc_q      <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
                        opnd_q     <= bus.op[1] ? b_mag : a_mag;
                        a_q        <= bus.a_in;
                        div_zero_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(N - 1)) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!bus.cancel) begin
                        hi_q       <= fix_hi;
                        lo_q       <= fix_lo;
                        div_zero_q <= dz_q;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - three radix builds checked against an arithmetic reference model
module tb_mdu_iterative;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start, cancel, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a_in, b_in, wdata;

    logic [W-1:0] d_hi[3];
    logic [W-1:0] d_lo[3];
    logic         d_busy[3];
    logic         d_done[3];
    logic         d_dz[3];

    mdu_iterative_if #(.WIDTH(W)) ifs[3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ifs[g].start  = start;
        assign ifs[g].op     = op;
        assign ifs[g].a_in   = a_in;
        assign ifs[g].b_in   = b_in;
        assign ifs[g].cancel = cancel;
        assign ifs[g].wr_hi  = wr_hi;
        assign ifs[g].wr_lo  = wr_lo;
        assign ifs[g].wdata  = wdata;
        assign d_hi[g]   = ifs[g].hi;
        assign d_lo[g]   = ifs[g].lo;
        assign d_busy[g] = ifs[g].busy;
        assign d_done[g] = ifs[g].done;
        assign d_dz[g]   = ifs[g].div_zero;
        mdu_iterative #(.WIDTH(W), .BPC(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (ifs[g])
        );
    end

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic per instruction definition.
    function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l, output bit z);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'(a);
        ub = longint'(b);
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            2'd1: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
            default: begin
                if (b == '0) begin
                    z = 1'b1; l = '1; h = a;
                end else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
                end else begin
                    up = ua / ub; l = up[31:0];
                    up = ua % ub; h = up[31:0];
                end
            end
        endcase
    endfunction

    // Per-build model: cycles of busy remaining plus the pending result.
    int           NS[3] = '{32, 16, 8};
    int           m_rem[3];
    logic [W-1:0] m_hi[3], m_lo[3], p_hi[3], p_lo[3];
    bit           m_dz[3], p_dz[3], m_done[3];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_rem[k] = 0; m_hi[k] = '0; m_lo[k] = '0; m_dz[k] = 1'b0; m_done[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (m_rem[k] > 0) begin
                    if (cancel) m_rem[k] = 0;
                    else begin
                        m_rem[k]--;
                        if (m_rem[k] == 0) begin
                            m_hi[k] = p_hi[k]; m_lo[k] = p_lo[k]; m_dz[k] = p_dz[k]; m_done[k] = 1'b1;
                        end
                    end
                end else begin
                    if (wr_hi) m_hi[k] = wdata;
                    if (wr_lo) m_lo[k] = wdata;
                    if (start && !cancel) begin
                        ref_op(op, a_in, b_in, p_hi[k], p_lo[k], p_dz[k]);
                        m_rem[k] = NS[k] + 1;
                        m_dz[k]  = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("busy", k, W'(d_busy[k]), W'(m_rem[k] > 0));
                chk("done", k, W'(d_done[k]), W'(m_done[k]));
                chk("div_zero", k, W'(d_dz[k]), W'(m_dz[k]));
                chk("hi", k, d_hi[k], m_hi[k]);
                chk("lo", k, d_lo[k], m_lo[k]);
            end
        end
    end

    // Called at a negedge; returns at the negedge where dut0 shows done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int busy_cnt, output bit got);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (d_done[0]) begin got = 1'b1; break; end
            if (d_busy[0]) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic expect_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int  bc;
        bit  got;
        run_op(o, a, b, bc, got);
        chk({name, "_done"}, 0, W'(got), W'(1));
        chk({name, "_busy_cycles"}, 0, W'(bc), W'(33));
        chk({name, "_hi"}, 0, d_hi[0], eh);
        chk({name, "_lo"}, 0, d_lo[0], el);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return W'($urandom_range(15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int  bc;
        bit  got;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = '0; a_in = '0; b_in = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 0, d_hi[0], '0);
        chk("rst_lo", 0, d_lo[0], '0);
        chk("rst_busy", 0, W'(d_busy[0]), '0);
        chk("rst_done", 0, W'(d_done[0]), '0);
        chk("rst_dz", 0, W'(d_dz[0]), '0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        expect_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        expect_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        expect_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        expect_op("divu_zero", 2'd3, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
        chk("divu_zero_flag", 0, W'(d_dz[0]), W'(1));
        expect_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        chk("div_ovf_flag", 0, W'(d_dz[0]), W'(0));
        // Issued in the done cycle of the previous op: must be accepted immediately.
        expect_op("b2b_multu", 2'd1, 32'd3, 32'd5, 32'd0, 32'd15);

        start = 1'b1; op = 2'd3; a_in = 32'd1000; b_in = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 0, W'(d_busy[0]), '0);
        chk("cancel_done", 0, W'(d_done[0]), '0);
        chk("cancel_hi", 0, d_hi[0], 32'd0);
        chk("cancel_lo", 0, d_lo[0], 32'd15);
        wr_lo = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo", 0, d_lo[0], 32'h1234_5678);
        repeat (40) @(negedge clk);

        start = 1'b1; op = 2'd0; a_in = 32'd123; b_in = 32'd456;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_hi", 0, d_hi[0], '0);
        chk("arst_lo", 0, d_lo[0], '0);
        chk("arst_busy", 0, W'(d_busy[0]), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        wr_hi = 1'b1; wdata = 32'hAAAA_5555;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi", 0, d_hi[0], 32'hAAAA_5555);
        start = 1'b1; op = 2'd1; a_in = 32'd3; b_in = 32'd5;
        @(negedge clk);
        wr_hi = 1'b1; wdata = 32'hDEAD_BEEF; start = 1'b1; op = 2'd3; a_in = 32'd9; b_in = 32'd2;
        @(negedge clk);
        wr_hi = 1'b0; start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (d_done[0]) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("ignore_done", 0, W'(got), W'(1));
        chk("ignore_hi", 0, d_hi[0], 32'd0);
        chk("ignore_lo", 0, d_lo[0], 32'd15);

        for (int c = 0; c < 20000; c++) begin
            start  = ($urandom_range(1) == 1);
            op     = 2'($urandom_range(3));
            a_in   = pick();
            b_in   = pick();
            cancel = ($urandom_range(63) == 0);
            wr_hi  = ($urandom_range(15) == 0);
            wr_lo  = ($urandom_range(15) == 0);
            wdata  = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        repeat (40) @(negedge clk);
        bc = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
